lc3_mem_arbiter: RTL

//  Parametrised N-channel arbiter between LC-3 requestors (CPU data port, fetch, DMA/frame copy) and one

---
 rtl/lc3_mem_arbiter_if.sv | 26 ++
 rtl/lc3_mem_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_arbiter_if.sv
// Requestor-side bus of lc3_mem_arbiter: per-channel request/command lanes
// and the shared completion signals (one-hot ack, rdata, err).
interface lc3_mem_arbiter_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH-1:0]        we;
    logic [NUM_CH-1:0]        ptr;
    logic [NUM_CH*ADDR_W-1:0] addr;
    logic [NUM_CH*DATA_W-1:0] wdata;
    logic [NUM_CH-1:0]        ack;
    logic [DATA_W-1:0]        rdata;
    logic                     err;

    modport master (
        output req, we, ptr, addr, wdata,
        input  ack, rdata, err
    );

    modport slave (
        input  req, we, ptr, addr, wdata,
        output ack, rdata, err
    );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// Round-robin N-channel arbiter in front of one single-port synchronous RAM, with
// internal PtrToPtr (LDI/STI) handling. Define LC3_ARB_WP_EN to enable write protection.
module lc3_mem_arbiter #(
    parameter int                NUM_CH = 3,
    parameter int                ADDR_W = 16,
    parameter int                DATA_W = 16,
    parameter logic [ADDR_W-1:0] WP_LO  = ADDR_W'(16'h0000),
    parameter logic [ADDR_W-1:0] WP_HI  = ADDR_W'(16'h2FFF)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    lc3_mem_arbiter_if.slave     bus,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic                 ram_we,
    output logic [DATA_W-1:0]    ram_wdata,
    input  logic [DATA_W-1:0]    ram_rdata
);

    localparam int              CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]   NUM_CH_V = (CH_W + 1)'(NUM_CH);
`ifdef LC3_ARB_WP_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        PFETCH,
        PLOAD,
        ACCESS,
        RESP
    } state_t;

    state_t              state_reg;
    logic [CH_W-1:0]     last_grant_reg;
    logic                we_lat_reg;
    logic                err_pend_reg;
    logic [NUM_CH-1:0]   ack_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic                err_reg;
    logic [ADDR_W-1:0]   ram_addr_reg;
    logic                ram_we_reg;
    logic [DATA_W-1:0]   ram_wdata_reg;

    // Unpack the flat per-channel address/data lanes.
    logic [ADDR_W-1:0] addr_arr  [NUM_CH];
    logic [DATA_W-1:0] wdata_arr [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = bus.wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // A channel being acked this cycle is masked so its still-high req cannot regrant it.
    logic [NUM_CH-1:0] cand_req;
    assign cand_req = bus.req & ~ack_reg;

    logic [CH_W-1:0] start_ch;
    logic [CH_W-1:0] sel_ch;
    logic            sel_vld;
    logic [CH_W:0]   scan;

    always_comb begin
        start_ch = (last_grant_reg == LAST_CH) ? '0 : last_grant_reg + CH_W'(1);
        sel_ch   = '0;
        sel_vld  = 1'b0;
        scan     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan = {1'b0, start_ch} + (CH_W + 1)'(k);
            if (scan >= NUM_CH_V) begin
                scan = scan - NUM_CH_V;
            end
            if (!sel_vld && cand_req[scan[CH_W-1:0]]) begin
                sel_vld = 1'b1;
                sel_ch  = scan[CH_W-1:0];
            end
        end
    end

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              sel_ptr;
    logic [ADDR_W-1:0] ptr_addr;
    logic              grant_wp;
    logic              load_wp;

    assign sel_addr  = addr_arr[sel_ch];
    assign sel_wdata = wdata_arr[sel_ch];
    assign sel_we    = bus.we[sel_ch];
    assign sel_ptr   = bus.ptr[sel_ch];
    assign ptr_addr  = ram_rdata[ADDR_W-1:0];

    // Protection only ever applies to the final (effective) write address.
    assign grant_wp = WP_EN && (sel_addr >= WP_LO) && (sel_addr <= WP_HI);
    assign load_wp  = WP_EN && (ptr_addr >= WP_LO) && (ptr_addr <= WP_HI);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= LAST_CH;
            we_lat_reg     <= 1'b0;
            err_pend_reg   <= 1'b0;
            ack_reg        <= '0;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
            ram_addr_reg   <= '0;
            ram_we_reg     <= 1'b0;
            ram_wdata_reg  <= '0;
        end else begin
            ack_reg <= '0;
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (sel_vld) begin
                        last_grant_reg <= sel_ch;
                        we_lat_reg     <= sel_we;
                        ram_addr_reg   <= sel_addr;
                        ram_wdata_reg  <= sel_wdata;
                        ram_we_reg     <= sel_we & ~sel_ptr & ~grant_wp;
                        err_pend_reg   <= sel_we & ~sel_ptr & grant_wp;
                        state_reg      <= sel_ptr ? PFETCH : ACCESS;
                    end
                end
                PFETCH: begin
                    ram_we_reg <= 1'b0;
                    state_reg  <= PLOAD;
                end
                PLOAD: begin
                    // Pointer word is on ram_rdata now; it becomes the effective address.
                    ram_addr_reg <= ptr_addr;
                    ram_we_reg   <= we_lat_reg & ~load_wp;
                    err_pend_reg <= we_lat_reg & load_wp;
                    state_reg    <= ACCESS;
                end
                ACCESS: begin
                    ram_we_reg <= 1'b0;
                    state_reg  <= RESP;
                end
                RESP: begin
                    rdata_reg               <= we_lat_reg ? '0 : ram_rdata;
                    ack_reg[last_grant_reg] <= 1'b1;
                    err_reg                 <= err_pend_reg;
                    state_reg               <= IDLE;
                end
                default: begin
                    ram_we_reg <= 1'b0;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack   = ack_reg;
    assign bus.rdata = rdata_reg;
    assign bus.err   = err_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_we    = ram_we_reg;
    assign ram_wdata = ram_wdata_reg;

endmodule
